// File: rtl/idct_mac_chain_if.sv
// Beat, result and coefficient-load bus of idct_mac_chain.
// master = upstream/downstream environment, slave = the MAC chain.
interface idct_mac_chain_if #(
  parameter int N  = 8,
  parameter int DW = 16,
  parameter int CW = 8,
  parameter int OW = 16
);
  localparam int ABW = (N > 1) ? $clog2(N) : 1;

  logic                 in_valid;
  logic                 in_ready;
  logic [N*DW-1:0]      d_in;
  logic [4:0]           shift;
  logic                 cfg_we;
  logic [ABW-1:0]       cfg_addr;
  logic signed [CW-1:0] cfg_data;
  logic                 out_valid;
  logic                 out_ready;
  logic signed [OW-1:0] out_data;
  logic [N*DW-1:0]      d_prop;
  logic                 sat_flag;

  modport master (
    output in_valid, d_in, shift, cfg_we, cfg_addr, cfg_data, out_ready,
    input  in_ready, out_valid, out_data, d_prop, sat_flag
  );

  modport slave (
    input  in_valid, d_in, shift, cfg_we, cfg_addr, cfg_data, out_ready,
    output in_ready, out_valid, out_data, d_prop, sat_flag
  );
endinterface

// File: rtl/idct_mac_chain.sv
// Systolic N-stage multiply-accumulate chain producing one IDCT output coefficient.
// Define IDCT_SAT_EN to clip results to OW bits and enable the sticky sat_flag.
module idct_mac_chain #(
  parameter int N  = 8,
  parameter int DW = 16,
  parameter int CW = 8,
  parameter int AW = 27,
  parameter int OW = 16
) (
  input  logic           clk,
  input  logic           reset,
  idct_mac_chain_if.slave bus
);
  localparam int PW = DW + CW;

  logic                 w_adv;
  logic signed [CW-1:0] r_coef [N];
  logic signed [AW-1:0] w_prod [N];
  logic signed [AW-1:0] r_acc [N-1];
  logic                 r_valid [N-1];
  logic [4:0]           r_sh [N-1];
  logic [N*DW-1:0]      r_d_prop;
  logic                 r_out_valid;
  logic signed [OW-1:0] r_out_data;
  logic signed [AW-1:0] w_rnd;
  logic signed [AW-1:0] w_sum;
  logic signed [OW-1:0] w_narrow;

  assign w_adv        = !r_out_valid || bus.out_ready;
  assign bus.in_ready = w_adv;

  // Address width is clog2(N) and N is a power of two, so every address is in range.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N; i++) r_coef[i] <= '0;
    end else if (bus.cfg_we) begin
      r_coef[bus.cfg_addr] <= bus.cfg_data;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_prod
      logic signed [PW-1:0] w_p;
      assign w_p        = $signed(bus.d_in[gi*DW +: DW]) * r_coef[gi];
      assign w_prod[gi] = {{(AW-PW){w_p[PW-1]}}, w_p};
    end

    for (gi = 1; gi < N-1; gi++) begin : g_stage
      always_ff @(posedge clk) begin
        if (reset) begin
          r_acc[gi]   <= '0;
          r_valid[gi] <= 1'b0;
          r_sh[gi]    <= '0;
        end else if (w_adv) begin
          r_acc[gi]   <= r_acc[gi-1] + w_prod[gi];
          r_valid[gi] <= r_valid[gi-1];
          r_sh[gi]    <= r_sh[gi-1];
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      r_acc[0]   <= '0;
      r_valid[0] <= 1'b0;
      r_sh[0]    <= '0;
    end else if (w_adv) begin
      r_acc[0]   <= w_prod[0];
      r_valid[0] <= bus.in_valid;
      r_sh[0]    <= bus.shift;
    end
  end

  // A rounding bit at position >= AW falls off the accumulator and contributes nothing.
  assign w_rnd = (r_sh[N-2] == 5'd0) ? '0 : (AW'(1) << (r_sh[N-2] - 5'd1));
  assign w_sum = r_acc[N-2] + w_prod[N-1] + w_rnd;

`ifdef IDCT_SAT_EN
  localparam logic signed [OW-1:0] MAX_V = {1'b0, {(OW-1){1'b1}}};
  localparam logic signed [OW-1:0] MIN_V = {1'b1, {(OW-1){1'b0}}};

  logic signed [AW-1:0] w_shifted;
  logic                 w_fits;
  logic                 r_sat;

  assign w_shifted = w_sum >>> r_sh[N-2];
  assign w_fits    = (w_shifted[AW-1:OW-1] == {(AW-OW+1){w_shifted[AW-1]}});
  assign w_narrow  = w_fits ? w_shifted[OW-1:0] : (w_shifted[AW-1] ? MIN_V : MAX_V);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sat <= 1'b0;
    end else if (w_adv && r_valid[N-2] && !w_fits) begin
      r_sat <= 1'b1;
    end
  end

  assign bus.sat_flag = r_sat;
`else
  assign w_narrow     = OW'(w_sum >>> r_sh[N-2]);
  assign bus.sat_flag = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_d_prop    <= '0;
    end else if (w_adv) begin
      r_out_valid <= r_valid[N-2];
      r_out_data  <= w_narrow;
      r_d_prop    <= bus.d_in;
    end
  end

  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.d_prop    = r_d_prop;
endmodule

// File: tb/tb_idct_mac_chain.sv
// Directed bench for idct_mac_chain: N=8 vector table with stall and reset cases,
// plus N=4 and N=32 instances for the point-count sweep.
module tb_idct_mac_chain;
  localparam int N  = 8;
  localparam int DW = 16;
  localparam int CW = 8;
  localparam int OW = 16;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  idct_mac_chain_if #(.N(8),  .DW(16), .CW(8), .OW(16)) bus8  ();
  idct_mac_chain_if #(.N(4),  .DW(16), .CW(8), .OW(16)) bus4  ();
  idct_mac_chain_if #(.N(32), .DW(16), .CW(8), .OW(16)) bus32 ();

  idct_mac_chain #(.N(8),  .DW(16), .CW(8), .AW(27), .OW(16)) dut8  (.clk(clk), .reset(reset), .bus(bus8));
  idct_mac_chain #(.N(4),  .DW(16), .CW(8), .AW(26), .OW(16)) dut4  (.clk(clk), .reset(reset), .bus(bus4));
  idct_mac_chain #(.N(32), .DW(16), .CW(8), .AW(29), .OW(16)) dut32 (.clk(clk), .reset(reset), .bus(bus32));

  typedef struct {
    string name;
    logic  vld;
    int    base;
    int    step;
    int    sh;
    int    exp;
  } vec_t;

  int checks   = 0;
  int failures = 0;

  vec_t                 tbl [12];
  int                   coef_std [8] = '{64, 50, -36, -89, -64, 18, 83, 75};
  logic signed [DW-1:0] smp  [16][N];
  logic                 bv   [16];
  logic [4:0]           bsh  [16];
  int                   bexp [16];
  string                bnm  [16];
  int                   nbeats = 0;

  task automatic chk(input string nm, input logic signed [127:0] act, input logic signed [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic load_beat(input int b, input vec_t v);
    for (int k = 0; k < N; k++) smp[b][k] = DW'(v.base + k * v.step);
    bv[b]   = v.vld;
    bsh[b]  = 5'(v.sh);
    bexp[b] = v.exp;
    bnm[b]  = v.name;
  endtask

  // Drive advance a: slice k carries sample k of beat a-k (external skew).
  task automatic apply(input int a);
    int b;
    bus8.in_valid = (a < nbeats) ? bv[a] : 1'b0;
    bus8.shift    = (a < nbeats) ? bsh[a] : 5'd0;
    for (int k = 0; k < N; k++) begin
      b = a - k;
      bus8.d_in[k*DW +: DW] = (b >= 0 && b < nbeats) ? smp[b][k] : '0;
    end
  endtask

  function automatic logic [N*DW-1:0] dprop_model(input int a);
    logic [N*DW-1:0] v;
    int b;
    v = '0;
    for (int k = 0; k < N; k++) begin
      b = a - k;
      if (b >= 0 && b < nbeats) v[k*DW +: DW] = smp[b][k];
    end
    return v;
  endfunction

  task automatic write_coef(input int addr, input int val);
    bus8.cfg_we   = 1'b1;
    bus8.cfg_addr = 3'(addr);
    bus8.cfg_data = CW'(val);
    @(posedge clk); #1;
    bus8.cfg_we   = 1'b0;
  endtask

  task automatic run_stream(input int stall_at, input int stall_len);
    int   b;
    logic exp_v;
    bus8.out_ready = 1'b1;
    for (int a = 0; a < nbeats + N - 1; a++) begin
      apply(a);
      if (a == stall_at) begin
        bus8.out_ready = 1'b0;
        for (int s = 0; s <= stall_len; s++) begin
          #1;
          chk("stall_in_ready",  bus8.in_ready, 0);
          chk("stall_out_valid", bus8.out_valid, 1);
          chk("stall_out_data",  $signed(bus8.out_data), bexp[a-N]);
          chk("stall_d_prop",    bus8.d_prop, dprop_model(a-1));
          if (s < stall_len) begin
            @(posedge clk); #1;
          end
        end
        bus8.out_ready = 1'b1;
      end
      @(posedge clk); #1;
      b     = a - N + 1;
      exp_v = (b >= 0 && b < nbeats) ? bv[b] : 1'b0;
      chk($sformatf("%s_out_valid", (b >= 0) ? bnm[b] : "lead"), bus8.out_valid, exp_v);
      if (exp_v) chk($sformatf("%s_out_data", bnm[b]), $signed(bus8.out_data), bexp[b]);
      chk($sformatf("d_prop_adv%0d", a), bus8.d_prop, dprop_model(a));
    end
  endtask

  initial begin
    int cnt;
    vec_t v;

    bus8.cfg_we = 1'b0; bus8.cfg_addr = '0; bus8.cfg_data = '0; bus8.out_ready = 1'b1;
    bus4.cfg_we = 1'b0; bus4.cfg_addr = '0; bus4.cfg_data = '0; bus4.out_ready = 1'b1;
    bus4.in_valid = 1'b0; bus4.shift = '0; bus4.d_in = '0;
    bus32.cfg_we = 1'b0; bus32.cfg_addr = '0; bus32.cfg_data = '0; bus32.out_ready = 1'b1;
    bus32.in_valid = 1'b0; bus32.shift = '0; bus32.d_in = '0;
    apply(0);

    tbl[0]  = '{"all1_sh0",    1'b1,   1, 0,  0,  101};
    tbl[1]  = '{"all1_sh7",    1'b1,   1, 0,  7,    1};
    tbl[2]  = '{"allm1_sh7",   1'b1,  -1, 0,  7,   -1};
    tbl[3]  = '{"bubble",      1'b0,   5, 0,  0,    0};
    tbl[4]  = '{"all2_sh1",    1'b1,   2, 0,  1,  101};
    tbl[5]  = '{"all100_sh3",  1'b1, 100, 0,  3, 1263};
    tbl[6]  = '{"allm3_sh2",   1'b1,  -3, 0,  2,  -76};
    tbl[7]  = '{"zero_sh5",    1'b1,   0, 0,  5,    0};
    tbl[8]  = '{"all1_sh31",   1'b1,   1, 0, 31,    0};
    tbl[9]  = '{"allm1_sh31",  1'b1,  -1, 0, 31,   -1};
    tbl[10] = '{"ramp_sh0",    1'b1,   1, 1,  0,  669};
    tbl[11] = '{"ramp2_sh2",   1'b1,  -4, 3,  2,  325};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", bus8.out_valid, 0);
    chk("rst_out_data",  $signed(bus8.out_data), 0);
    chk("rst_d_prop",    bus8.d_prop, 0);
    chk("rst_sat_flag",  bus8.sat_flag, 0);
    chk("rst_in_ready",  bus8.in_ready, 1);
    reset = 1'b0;

    // Point-count sweep: coef all 1, sample k = k
    for (int i = 0; i < 32; i++) begin
      bus32.cfg_we = 1'b1; bus32.cfg_addr = 5'(i); bus32.cfg_data = 8'sd1;
      bus4.cfg_we = (i < 4); bus4.cfg_addr = 2'(i); bus4.cfg_data = 8'sd1;
      @(posedge clk); #1;
    end
    bus32.cfg_we = 1'b0;
    bus4.cfg_we  = 1'b0;
    for (int a = 0; a < 32; a++) begin
      bus4.in_valid  = (a == 0);
      bus32.in_valid = (a == 0);
      for (int k = 0; k < 4; k++)  bus4.d_in[k*16 +: 16]  = (a == k) ? 16'(k) : 16'd0;
      for (int k = 0; k < 32; k++) bus32.d_in[k*16 +: 16] = (a == k) ? 16'(k) : 16'd0;
      @(posedge clk); #1;
      if (a == 2)  chk("n4_early_valid", bus4.out_valid, 0);
      if (a == 3)  chk("n4_out_valid",   bus4.out_valid, 1);
      if (a == 3)  chk("n4_out_data",    $signed(bus4.out_data), 6);
      if (a == 30) chk("n32_early_valid", bus32.out_valid, 0);
      if (a == 31) chk("n32_out_valid",   bus32.out_valid, 1);
      if (a == 31) chk("n32_out_data",    $signed(bus32.out_data), 496);
    end

    // Main vector table, back to back, with a 3-cycle output stall
    for (int i = 0; i < N; i++) write_coef(i, coef_std[i]);
    nbeats = 12;
    for (int i = 0; i < 12; i++) load_beat(i, tbl[i]);
    run_stream(N + 2, 3);
    chk("sat_flag_clean", bus8.sat_flag, 0);

    // Saturation
    nbeats = 0;
    apply(0);
    write_coef(0, 64);
    for (int i = 1; i < N; i++) write_coef(i, 0);
    nbeats = 1;
`ifdef IDCT_SAT_EN
    v = '{"sat_32767", 1'b1, 32767, 0, 0, 32767};
`else
    v = '{"sat_32767", 1'b1, 32767, 0, 0, -64};
`endif
    load_beat(0, v);
    run_stream(-1, 0);
`ifdef IDCT_SAT_EN
    chk("sat_flag_set", bus8.sat_flag, 1);
`else
    chk("sat_flag_set", bus8.sat_flag, 0);
`endif

    // Reset four cycles into a beat
    nbeats = 0;
    apply(0);
    for (int i = 0; i < N; i++) write_coef(i, coef_std[i]);
    nbeats = 1;
    load_beat(0, tbl[0]);
    for (int a = 0; a < 4; a++) begin
      apply(a);
      @(posedge clk); #1;
    end
    apply(4);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_out_valid", bus8.out_valid, 0);
    chk("mid_rst_out_data",  $signed(bus8.out_data), 0);
    chk("mid_rst_d_prop",    bus8.d_prop, 0);
    chk("mid_rst_sat_flag",  bus8.sat_flag, 0);
    chk("mid_rst_in_ready",  bus8.in_ready, 1);
    reset  = 1'b0;
    nbeats = 0;
    apply(0);
    cnt = 0;
    for (int i = 0; i < N + 2; i++) begin
      @(posedge clk); #1;
      if (bus8.out_valid) cnt++;
    end
    chk("mid_rst_no_valid", cnt, 0);

    nbeats = 1;
    v = '{"coef_cleared", 1'b1, 1, 0, 0, 0};
    load_beat(0, v);
    run_stream(-1, 0);

    nbeats = 0;
    apply(0);
    for (int i = 0; i < N; i++) write_coef(i, coef_std[i]);
    nbeats = 1;
    v = '{"reloaded", 1'b1, 1, 0, 0, 101};
    load_beat(0, v);
    run_stream(-1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
